sipo_frame_asm: RTL and testbench
=================================

# sipo_frame_asm

Parametrised serial-to-parallel frame assembler between the FIR decimator output and the FFT input of the frequency-analysis datapath. It collects signed samples into N-sample frames, oldest sample at lane 0. Frames can overlap: a new frame is emitted every HOP samples once the first frame is full. Completed frames are held in an output register with a valid/ready handshake; the serial input never stalls, so a frame that arrives while the held one is unaccepted is dropped and counted.

## Interface
- DATA_W, 16, sample width in bits (signed two's complement)
- N, 16, frame length in samples (≥2)
- HOP, 16, samples between successive frames (1..N; HOP=N means no overlap)
- CNT_W, 16, width of the dropped-frame counter
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  sample strobe, always accepted
- in_data  in  DATA_W  signed sample
- flush  in  1  discard partial frame and restart fill
- out_valid  out  1  held frame available
- out_ready  in  1  consumer accepts held frame
- out_data  out  N*DATA_W  held frame; lane i = bits [i*DATA_W +: DATA_W], lane 0 oldest
- overflow  out  1  one-cycle pulse when a completed frame is dropped
- drop_cnt  out  CNT_W  dropped frames since reset, saturating

## Operation
- Shift register of N lanes: on in_valid, lane N-1 ← in_data and lane i ← lane i+1.
- States: FILL, RUN. Reset and flush enter FILL with fill_cnt=0.
- FILL: fill_cnt counts accepted samples. The sample that makes fill_cnt reach N completes a frame. Go to RUN with hop_cnt=0.
- RUN: hop_cnt counts accepted samples. The sample that makes hop_cnt reach HOP completes a frame. hop_cnt returns to 0.
- Frame completion captures the shift contents including the completing sample, i.e. the post-shift value, into the holding register.
- Holding register is written only when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle.
- Otherwise the completed frame is discarded:
  - overflow pulses for one cycle.
  - drop_cnt increments, saturating at 2^CNT_W−1.
  - The held frame is unchanged.
- out_valid clears on out_valid & out_ready with no simultaneous completion.
- Flush:
  - Clears the shift register to 0 and counters to 0, and enters FILL.
  - Does not touch out_valid, out_data or drop_cnt.
  - If flush and in_valid occur together, flush wins and the sample is discarded.
- Reset values: out_valid=0, out_data=0, overflow=0, drop_cnt=0, shift lanes=0, state FILL.
- No arithmetic on data; samples pass bit-exact.

## Timing
- Latency: completing sample sampled at edge k → out_valid=1 and out_data valid after edge k.
- Handshake: transfer occurs on the edge where out_valid & out_ready=1. out_data is stable while out_valid=1 and no transfer occurs.
- Simultaneous transfer and completion: the new frame loads, out_valid stays 1, no overflow.
- out_ready while out_valid=0 has no effect.
- Back-to-back completions with HOP=1 are supported at one frame per in_valid when out_ready is held high.
- Reset assertion mid-frame clears all state immediately. The first frame after reset release needs N fresh samples.
- in_valid gaps of any length do not affect counts.

## Structure
- Shared package sipo_pkg holds:
  - state enum (FILL, RUN)
  - a clog2-based counter-width function for fill/hop counters (width clog2(N+1))
  - the lane-slice convention used by the FFT input
- One sub-module, sipo_shift_lanes: parametrised N×DATA_W shift register with enable and synchronous clear (for flush). Control FSM, holding register and drop counter live in the top.

## Test plan
- Default params, out_ready=1, feed 1..16 → one out_valid; lane0=1, lane15=16; out_valid rises after the 16th in_valid edge.
- HOP=8, feed 1..24 with out_ready=1 → two frames: 1..16, then 9..24; no overflow.
- out_ready=0, feed 1..32 → frame 1..16 held; at sample 32 overflow pulses once, drop_cnt=1, out_data still 1..16.
- Feed 5 samples, pulse flush, feed 100..115 → single frame 100..115; flush coincident with in_valid drops that sample.
- Held frame pending; out_ready=1 on the same cycle as the completing sample of the next frame → new frame loads, out_valid stays 1, drop_cnt unchanged.
- Assert rst after 10 samples, release, feed 1..16 → all outputs zero during reset; first frame is exactly 1..16.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-to-parallel frame assembler
// that sits between the FIR decimator and the FFT input.
package sipo_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Fill/hop counter width: must be able to hold values up to N.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // FFT input convention: lane i occupies bits [lane_lsb(i,w) +: w], lane 0 oldest.
  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/sipo_frame_asm_if.sv
// Sample-in / frame-out bundle of the frame assembler.
interface sipo_frame_asm_if #(
  parameter int DATA_W = 16,
  parameter int N      = 16,
  parameter int CNT_W  = 16
);
  logic                  in_valid;
  logic [DATA_W-1:0]     in_data;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [N*DATA_W-1:0]   out_data;
  logic                  overflow;
  logic [CNT_W-1:0]      drop_cnt;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  out_valid, out_data, overflow, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output out_valid, out_data, overflow, drop_cnt
  );
endinterface

// File: rtl/sipo_shift_lanes.sv
// N x DATA_W sample shift register: newest sample enters lane N-1, lane 0 is oldest.
// Exposes the post-update contents so a completing sample lands in the captured frame.
module sipo_shift_lanes #(
  parameter int DATA_W = 16,
  parameter int N      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        clr,
  input  logic [DATA_W-1:0]           din,
  output logic [N-1:0][DATA_W-1:0]    nxt_o
);

  logic [N-1:0][DATA_W-1:0] lanes_q, lanes_d, shifted;

  for (genvar i = 0; i < N; i++) begin : g_lane
    if (i == N - 1) begin : g_top
      assign shifted[i] = din;
    end else begin : g_mid
      assign shifted[i] = lanes_q[i+1];
    end
  end

  // Clear beats shift so a sample coincident with flush is discarded.
  always_comb begin
    lanes_d = lanes_q;
    if (clr)     lanes_d = '0;
    else if (en) lanes_d = shifted;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lanes_q <= '0;
    else      lanes_q <= lanes_d;
  end

  assign nxt_o = lanes_d;

endmodule

// File: rtl/sipo_frame_asm.sv
// Frame assembler top: fill/hop control FSM, held-frame register with valid/ready,
// and a saturating count of frames dropped because the held one was not taken.
module sipo_frame_asm
  import sipo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int N      = 16,
  parameter int HOP    = 16,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  sipo_frame_asm_if.slave    bus
);

  localparam int             CW        = cnt_w(N);
  localparam logic [CW-1:0]  FILL_LAST = CW'(N - 1);
  localparam logic [CW-1:0]  HOP_LAST  = CW'(HOP - 1);

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      complete;

  logic [N-1:0][DATA_W-1:0]  lanes_nxt;
  logic [N-1:0][DATA_W-1:0]  hold_q, hold_d;
  logic                      valid_q, valid_d;
  logic                      ovf_q, ovf_d;
  logic [CNT_W-1:0]          drop_q, drop_d;

  sipo_shift_lanes #(
    .DATA_W (DATA_W),
    .N      (N)
  ) u_lanes (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.in_valid),
    .clr   (bus.flush),
    .din   (bus.in_data),
    .nxt_o (lanes_nxt)
  );

  // Control FSM: one shared counter, counting to N in FILL and to HOP in RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    if (bus.flush) begin
      state_d = FILL;
      cnt_d   = '0;
    end else if (bus.in_valid) begin
      case (state_q)
        FILL: begin
          if (cnt_q == FILL_LAST) begin
            complete = 1'b1;
            state_d  = RUN;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RUN: begin
          if (cnt_q == HOP_LAST) begin
            complete = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = FILL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A completion may replace the held frame only if it is absent or leaving this cycle.
  always_comb begin
    hold_d  = hold_q;
    valid_d = valid_q;
    ovf_d   = 1'b0;
    drop_d  = drop_q;
    if (complete) begin
      if (!valid_q || bus.out_ready) begin
        hold_d  = lanes_nxt;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
        if (drop_q != '1) drop_d = drop_q + CNT_W'(1);
      end
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      hold_q  <= hold_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_out
    assign bus.out_data[lane_lsb(g, DATA_W) +: DATA_W] = hold_q[g];
  end

  assign bus.out_valid = valid_q;
  assign bus.overflow  = ovf_q;
  assign bus.drop_cnt  = drop_q;

endmodule

// File: tb/tb_sipo_frame_asm.sv
// Directed bench for sipo_frame_asm: default (N=HOP=16), overlapped (HOP=8, 2-bit
// drop counter) and HOP=1 (N=4, 8-bit samples) instances sharing clock and reset.
module tb_sipo_frame_asm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  sipo_frame_asm_if #(.DATA_W(16), .N(16), .CNT_W(16)) ifa ();
  sipo_frame_asm_if #(.DATA_W(16), .N(16), .CNT_W(2))  ifb ();
  sipo_frame_asm_if #(.DATA_W(8),  .N(4),  .CNT_W(4))  ifc ();

  sipo_frame_asm #(.DATA_W(16), .N(16), .HOP(16), .CNT_W(16)) dut_a (.clk(clk), .rst(rst_n), .bus(ifa));
  sipo_frame_asm #(.DATA_W(16), .N(16), .HOP(8),  .CNT_W(2))  dut_b (.clk(clk), .rst(rst_n), .bus(ifb));
  sipo_frame_asm #(.DATA_W(8),  .N(4),  .HOP(1),  .CNT_W(4))  dut_c (.clk(clk), .rst(rst_n), .bus(ifc));

  function automatic logic [255:0] ramp16(input int s);
    logic [255:0] r = '0;
    for (int i = 0; i < 16; i++) r[i*16 +: 16] = 16'(s + i);
    return r;
  endfunction

  function automatic logic [255:0] ramp8x4(input int s);
    logic [255:0] r = '0;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'(s + i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic feed_a(input int first, input int last, input int gap);
    for (int s = first; s <= last; s++) begin
      ifa.in_valid = 1'b1; ifa.in_data = 16'(s);
      tick();
      ifa.in_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic feed_b(input int first, input int last);
    for (int s = first; s <= last; s++) begin
      ifb.in_valid = 1'b1; ifb.in_data = 16'(s);
      tick();
      ifb.in_valid = 1'b0;
    end
  endtask

  task automatic feed_c(input int first, input int last);
    for (int s = first; s <= last; s++) begin
      ifc.in_valid = 1'b1; ifc.in_data = 8'(s);
      tick();
      ifc.in_valid = 1'b0;
    end
  endtask

  initial begin
    ifa.in_valid = 0; ifa.in_data = '0; ifa.flush = 0; ifa.out_ready = 0;
    ifb.in_valid = 0; ifb.in_data = '0; ifb.flush = 0; ifb.out_ready = 0;
    ifc.in_valid = 0; ifc.in_data = '0; ifc.flush = 0; ifc.out_ready = 0;
    tick(); tick();
    chk("rst_valid", 256'(ifa.out_valid), 256'(0));
    chk("rst_data",  256'(ifa.out_data),  256'(0));
    chk("rst_ovf",   256'(ifa.overflow),  256'(0));
    chk("rst_drop",  256'(ifa.drop_cnt),  256'(0));
    rst_n = 1'b1;
    tick();

    // Basic fill: one frame after the 16th sample.
    ifa.out_ready = 1'b1;
    feed_a(1, 15, 0);
    chk("fill_not_yet", 256'(ifa.out_valid), 256'(0));
    feed_a(16, 16, 0);
    chk("fill_valid", 256'(ifa.out_valid), 256'(1));
    chk("fill_data",  256'(ifa.out_data),  ramp16(1));
    tick();
    chk("fill_taken", 256'(ifa.out_valid), 256'(0));

    // Overflow with the consumer stalled.
    ifa.flush = 1'b1; tick(); ifa.flush = 1'b0;
    ifa.out_ready = 1'b0;
    feed_a(1, 31, 0);
    chk("ovf_held_valid", 256'(ifa.out_valid), 256'(1));
    chk("ovf_none_yet",   256'(ifa.overflow),  256'(0));
    feed_a(32, 32, 0);
    chk("ovf_pulse", 256'(ifa.overflow), 256'(1));
    chk("ovf_drop",  256'(ifa.drop_cnt), 256'(1));
    chk("ovf_data",  256'(ifa.out_data), ramp16(1));
    feed_a(33, 47, 0);
    chk("ovf_one_cycle", 256'(ifa.overflow), 256'(0));

    // Transfer and completion on the same edge: new frame loads, no drop.
    ifa.out_ready = 1'b1;
    feed_a(48, 48, 0);
    chk("swap_valid", 256'(ifa.out_valid), 256'(1));
    chk("swap_data",  256'(ifa.out_data),  ramp16(33));
    chk("swap_ovf",   256'(ifa.overflow),  256'(0));
    chk("swap_drop",  256'(ifa.drop_cnt),  256'(1));
    tick();
    chk("swap_taken", 256'(ifa.out_valid), 256'(0));
    ifa.out_ready = 1'b0;

    // Flush mid-fill, with a coincident sample that must be discarded; gaps between samples.
    feed_a(1, 5, 1);
    ifa.flush = 1'b1; ifa.in_valid = 1'b1; ifa.in_data = 16'd99;
    tick();
    ifa.flush = 1'b0; ifa.in_valid = 1'b0;
    feed_a(100, 114, 1);
    chk("flush_not_yet", 256'(ifa.out_valid), 256'(0));
    feed_a(115, 115, 0);
    chk("flush_valid", 256'(ifa.out_valid), 256'(1));
    chk("flush_data",  256'(ifa.out_data),  ramp16(100));
    ifa.flush = 1'b1; tick(); ifa.flush = 1'b0;
    chk("flush_keeps_valid", 256'(ifa.out_valid), 256'(1));
    chk("flush_keeps_data",  256'(ifa.out_data),  ramp16(100));
    chk("flush_keeps_drop",  256'(ifa.drop_cnt),  256'(1));
    ifa.out_ready = 1'b1; tick();

    // Asynchronous reset mid-frame, then a clean first frame.
    feed_a(1, 10, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 256'(ifa.out_valid), 256'(0));
    chk("arst_data",  256'(ifa.out_data),  256'(0));
    chk("arst_drop",  256'(ifa.drop_cnt),  256'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();
    feed_a(1, 15, 0);
    chk("post_rst_not_yet", 256'(ifa.out_valid), 256'(0));
    feed_a(16, 16, 0);
    chk("post_rst_data", 256'(ifa.out_data), ramp16(1));

    // HOP=8: overlapping frames, then saturation of a 2-bit drop counter.
    ifb.out_ready = 1'b1;
    feed_b(1, 16);
    chk("hop_f1", 256'(ifb.out_data), ramp16(1));
    feed_b(17, 24);
    chk("hop_f2",     256'(ifb.out_data),  ramp16(9));
    chk("hop_f2_vld", 256'(ifb.out_valid), 256'(1));
    chk("hop_no_ovf", 256'(ifb.drop_cnt),  256'(0));
    ifb.out_ready = 1'b0;
    feed_b(25, 48);
    chk("sat_drop3", 256'(ifb.drop_cnt), 256'(3));
    feed_b(49, 56);
    chk("sat_hold",  256'(ifb.drop_cnt), 256'(3));
    chk("sat_pulse", 256'(ifb.overflow), 256'(1));
    chk("sat_data",  256'(ifb.out_data), ramp16(9));

    // HOP=1: one frame per sample with the consumer always ready.
    ifc.out_ready = 1'b1;
    feed_c(1, 3);
    chk("hop1_not_yet", 256'(ifc.out_valid), 256'(0));
    for (int s = 4; s <= 6; s++) begin
      feed_c(s, s);
      chk("hop1_data", 256'(ifc.out_data), ramp8x4(s - 3));
      chk("hop1_ovf",  256'(ifc.overflow), 256'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
